// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator result display stage.
package calc_display_pkg;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_DIGITS = 5;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 7-segment decoder; minus wins over blank, blank wins over the digit.
module seg7_decoder
    import calc_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    // Look up the glyph, then let the sign and blanking controls override it.
    always_comb begin
        seg = SEG_TABLE[digit];
        if (minus) begin
            seg = SEG_MINUS;
        end else if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// Display stage of the calculator: sequential binary-to-BCD conversion of the
// result word plus a multiplexed 6-digit 7-segment scan.
// Optional feature: define SIGNED_DISPLAY_EN to treat the value as two's
// complement and show a '-' on digit 5 for negative results.
module result_display_driver
    import calc_display_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int LEADING_BLANK = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [15:0] value,
    output logic        busy,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [5:0]  an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    state_t        state, state_next;
    logic [15:0]   src, src_next;
    logic [15:0]   shreg, shreg_next;
    logic [19:0]   scratch, scratch_next;
    logic [3:0]    cnt, cnt_next;
    logic [19:0]   bcd_next;
    logic          busy_next;
    logic          pend_neg, pend_neg_next;
    logic          neg, neg_next;

    logic [15:0]   mag;
    logic          value_neg;
    logic [19:0]   adjusted;
    logic [35:0]   dd_shifted;

`ifdef SIGNED_DISPLAY_EN
    assign value_neg = value[15];
    assign mag       = value[15] ? (~value + 16'd1) : value;
`else
    assign value_neg = 1'b0;
    assign mag       = value;
`endif

    // Double-dabble step: add 3 to every scratch nibble >= 5 before the shift.
    always_comb begin
        adjusted = scratch;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    assign dd_shifted = {adjusted, shreg} << 1;

    // Next-state logic: start a conversion on a new value, commit after 16 shifts.
    always_comb begin
        state_next    = state;
        src_next      = src;
        shreg_next    = shreg;
        scratch_next  = scratch;
        cnt_next      = cnt;
        bcd_next      = bcd;
        busy_next     = busy;
        pend_neg_next = pend_neg;
        neg_next      = neg;
        case (state)
            IDLE: begin
                if (value != src) begin
                    src_next      = value;
                    shreg_next    = mag;
                    scratch_next  = '0;
                    cnt_next      = '0;
                    pend_neg_next = value_neg;
                    busy_next     = 1'b1;
                    state_next    = CONV;
                end
            end
            CONV: begin
                scratch_next = dd_shifted[35:16];
                shreg_next   = dd_shifted[15:0];
                cnt_next     = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    bcd_next   = dd_shifted[35:16];
                    neg_next   = pend_neg;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Conversion state register; clear aborts any conversion without committing.
    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            src      <= '0;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            bcd      <= '0;
            busy     <= 1'b0;
            pend_neg <= 1'b0;
            neg      <= 1'b0;
        end else begin
            state    <= state_next;
            src      <= src_next;
            shreg    <= shreg_next;
            scratch  <= scratch_next;
            cnt      <= cnt_next;
            bcd      <= bcd_next;
            busy     <= busy_next;
            pend_neg <= pend_neg_next;
            neg      <= neg_next;
        end
    end

    logic [PW-1:0] pre, pre_next;
    logic [2:0]    idx, idx_next;
    logic [4:0]    lit;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic          cur_minus;
    logic [6:0]    seg_next;
    logic [5:0]    an_next;

    // Scan timing: the prescaler wrap advances the digit slot 0..5.
    always_comb begin
        pre_next = pre + 1'b1;
        idx_next = idx;
        if (pre == PRE_LAST) begin
            pre_next = '0;
            idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // A digit is lit if it or any higher digit is non-zero; digit 0 always lit.
    always_comb begin
        logic any_higher;
        any_higher = 1'b0;
        lit        = '0;
        lit[0]     = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            any_higher = any_higher | (bcd[4*i +: 4] != 4'd0);
            lit[i]     = any_higher | (LEADING_BLANK == 0);
        end
    end

    // Pick the digit and its controls for the slot being displayed next.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b1;
        cur_minus = 1'b0;
        case (idx_next)
            3'd0: begin cur_digit = bcd[3:0];   cur_blank = ~lit[0]; end
            3'd1: begin cur_digit = bcd[7:4];   cur_blank = ~lit[1]; end
            3'd2: begin cur_digit = bcd[11:8];  cur_blank = ~lit[2]; end
            3'd3: begin cur_digit = bcd[15:12]; cur_blank = ~lit[3]; end
            3'd4: begin cur_digit = bcd[19:16]; cur_blank = ~lit[4]; end
            default: begin
                cur_blank = ~neg;
                cur_minus = neg;
            end
        endcase
    end

    seg7_decoder u_decoder (
        .digit (cur_digit),
        .blank (cur_blank),
        .minus (cur_minus),
        .seg   (seg_next)
    );

    assign an_next = 6'b111111 ^ (6'b000001 << idx_next);

    // Registered scan outputs, driven from the post-update slot and committed bcd.
    always_ff @(posedge clk) begin
        if (clear) begin
            pre <= '0;
            idx <= 3'd0;
            an  <= 6'b111110;
            seg <= SEG_TABLE[0];
        end else begin
            pre <= pre_next;
            idx <= idx_next;
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
